// File: rtl/msrv32_pipe_pkg.sv
// Shared definitions for the handshaked pipeline stage register: stage state
// encoding and the packed decode->execute bundle layout (LSB first).
package msrv32_pipe_pkg;

    // State values double as the stored-bundle count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int RD_ADDR_W       = 5;
    localparam int CSR_ADDR_W      = 12;
    localparam int XLEN            = 32;
    localparam int ALU_OPCODE_W    = 4;
    localparam int LOAD_SIZE_W     = 2;
    localparam int WB_MUX_SEL_W    = 3;
    localparam int CSR_OP_W        = 3;

    localparam int RD_ADDR_POS       = 0;
    localparam int CSR_ADDR_POS      = RD_ADDR_POS + RD_ADDR_W;
    localparam int RS_1_POS          = CSR_ADDR_POS + CSR_ADDR_W;
    localparam int RS_2_POS          = RS_1_POS + XLEN;
    localparam int PC_POS            = RS_2_POS + XLEN;
    localparam int PC_PLUS_4_POS     = PC_POS + XLEN;
    localparam int IADDER_POS        = PC_PLUS_4_POS + XLEN;
    localparam int IMM_POS           = IADDER_POS + XLEN;
    localparam int ALU_OPCODE_POS    = IMM_POS + XLEN;
    localparam int LOAD_SIZE_POS     = ALU_OPCODE_POS + ALU_OPCODE_W;
    localparam int LOAD_UNSIGNED_POS = LOAD_SIZE_POS + LOAD_SIZE_W;
    localparam int ALU_SRC_POS       = LOAD_UNSIGNED_POS + 1;
    localparam int CSR_WR_EN_POS     = ALU_SRC_POS + 1;
    localparam int RF_WR_EN_POS      = CSR_WR_EN_POS + 1;
    localparam int WB_MUX_SEL_POS    = RF_WR_EN_POS + 1;
    localparam int CSR_OP_POS        = WB_MUX_SEL_POS + WB_MUX_SEL_W;
    localparam int DEC_EXE_BUNDLE_W  = CSR_OP_POS + CSR_OP_W;

    // A taken branch clears bit 0 of the computed target in iadder.
    localparam int IADDER_LSB_POS    = IADDER_POS;

endpackage

// File: rtl/msrv32_pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module msrv32_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/msrv32_pipe_stage_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer, flush,
// optional LSB clear on capture and a saturating output-stall counter.
module msrv32_pipe_stage_reg
    import msrv32_pipe_pkg::*;
#(
    parameter int              DATA_W      = 32,
    parameter logic [DATA_W-1:0] RST_VAL   = '0,
    parameter bit              LSB_CLR_EN  = 1'b1,
    parameter int              LSB_CLR_POS = 0,
    parameter int              STALL_CNT_W = 16
) (
    input  logic                   ms_riscv32_mp_clk_in,
    input  logic                   ms_riscv32_mp_rst_n_in,
    input  logic                   flush_in,
    input  logic                   in_valid_in,
    output logic                   in_ready_out,
    input  logic [DATA_W-1:0]      in_data_in,
    input  logic                   in_lsb_clr_in,
    output logic                   out_valid_out,
    input  logic                   out_ready_in,
    output logic [DATA_W-1:0]      out_data_out,
    output logic [1:0]             occupancy_out,
    input  logic                   stall_cnt_clr_in,
    output logic [STALL_CNT_W-1:0] stall_cnt_out
);

    localparam logic [DATA_W-1:0] CLR_MASK =
        LSB_CLR_EN ? ~(DATA_W'(1) << LSB_CLR_POS) : {DATA_W{1'b1}};

    pipe_state_e       state, state_nxt;
    logic [DATA_W-1:0] main_q, skid_q, cap;
    logic              in_xfer, out_xfer;
    logic              main_ld_cap, main_ld_skid, skid_ld;

    assign in_xfer  = in_valid_in & in_ready_out;
    assign out_xfer = out_valid_out & out_ready_in;
    assign cap      = in_lsb_clr_in ? (in_data_in & CLR_MASK) : in_data_in;

    // Flush overrides everything; storage is left untouched, only state drops.
    always_comb begin
        state_nxt    = state;
        main_ld_cap  = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        if (flush_in) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state_nxt   = ONE;
                        main_ld_cap = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_ld_cap = 1'b1;
                    end else if (in_xfer) begin
                        state_nxt = FULL;
                        skid_ld   = 1'b1;
                    end else if (out_xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_nxt    = ONE;
                        main_ld_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state        <= EMPTY;
            in_ready_out <= 1'b0;
            main_q       <= RST_VAL;
            skid_q       <= RST_VAL;
        end else begin
            state        <= state_nxt;
            in_ready_out <= (state_nxt != FULL);
            if (main_ld_cap) begin
                main_q <= cap;
            end else if (main_ld_skid) begin
                main_q <= skid_q;
            end
            if (skid_ld) begin
                skid_q <= cap;
            end
        end
    end

    assign out_valid_out = (state != EMPTY);
    assign out_data_out  = main_q;
    assign occupancy_out = state;

    msrv32_sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (ms_riscv32_mp_clk_in),
        .rst_n (ms_riscv32_mp_rst_n_in),
        .inc   (out_valid_out & ~out_ready_in),
        .clr   (stall_cnt_clr_in),
        .count (stall_cnt_out)
    );

endmodule

// File: tb/tb_msrv32_pipe_stage_reg.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a queue-based model of the stage.
module tb_msrv32_pipe_stage_reg;

    localparam logic [31:0] RST = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0, in_valid = 1'b0, in_lsb_clr = 1'b0;
    logic        out_ready = 1'b0, scclr = 1'b0;
    logic [31:0] in_data = '0;

    logic        rdy0, vld0, rdy1, vld1;
    logic [31:0] dat0, dat1;
    logic [1:0]  occ0, occ1;
    logic [3:0]  stl0;
    logic [15:0] stl1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    msrv32_pipe_stage_reg #(
        .DATA_W(32), .RST_VAL(RST), .LSB_CLR_EN(1'b1), .LSB_CLR_POS(0), .STALL_CNT_W(4)
    ) dut (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n), .flush_in(flush),
        .in_valid_in(in_valid), .in_ready_out(rdy0), .in_data_in(in_data),
        .in_lsb_clr_in(in_lsb_clr), .out_valid_out(vld0), .out_ready_in(out_ready),
        .out_data_out(dat0), .occupancy_out(occ0), .stall_cnt_clr_in(scclr),
        .stall_cnt_out(stl0)
    );

    msrv32_pipe_stage_reg #(
        .DATA_W(32), .RST_VAL(RST), .LSB_CLR_EN(1'b0), .LSB_CLR_POS(0), .STALL_CNT_W(16)
    ) dut_nc (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n), .flush_in(flush),
        .in_valid_in(in_valid), .in_ready_out(rdy1), .in_data_in(in_data),
        .in_lsb_clr_in(in_lsb_clr), .out_valid_out(vld1), .out_ready_in(out_ready),
        .out_data_out(dat1), .occupancy_out(occ1), .stall_cnt_clr_in(scclr),
        .stall_cnt_out(stl1)
    );

    // Model: stored bundles as a FIFO; the head is what the consumer sees.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] m_main0, m_main1;
    bit          m_ready;
    int          m_stall;

    always @(posedge clk or negedge rst_n) begin
        bit          ix, ox;
        logic [31:0] c0;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_main0 = RST;
            m_main1 = RST;
            m_ready = 1'b0;
            m_stall = 0;
        end else begin
            ix = in_valid && m_ready;
            ox = (q0.size() != 0) && out_ready;
            if (scclr) m_stall = 0;
            else if ((q0.size() != 0) && !out_ready) m_stall = m_stall + 1;
            if (flush) begin
                q0.delete();
                q1.delete();
            end else begin
                if (ox) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                end
                if (ix) begin
                    c0 = in_data;
                    if (in_lsb_clr) c0[0] = 1'b0;
                    q0.push_back(c0);
                    q1.push_back(in_data);
                end
                if (q0.size() != 0) begin
                    m_main0 = q0[0];
                    m_main1 = q1[0];
                end
            end
            m_ready = (q0.size() < 2);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] d, input bit clr,
                                 input bit ordy, input bit fl, input bit sc);
        in_valid   = v;
        in_data    = d;
        in_lsb_clr = clr;
        out_ready  = ordy;
        flush      = fl;
        scclr      = sc;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("out_valid", 64'(vld0), 64'(q0.size() != 0));
            checkOutput("in_ready", 64'(rdy0), 64'(m_ready));
            checkOutput("occupancy", 64'(occ0), 64'(q0.size()));
            checkOutput("out_data", 64'(dat0), 64'(m_main0));
            checkOutput("stall4", 64'(stl0), 64'((m_stall > 15) ? 15 : m_stall));
            checkOutput("nc_out_valid", 64'(vld1), 64'(q1.size() != 0));
            checkOutput("nc_in_ready", 64'(rdy1), 64'(m_ready));
            checkOutput("nc_occupancy", 64'(occ1), 64'(q1.size()));
            checkOutput("nc_out_data", 64'(dat1), 64'(m_main1));
            checkOutput("stall16", 64'(stl1), 64'((m_stall > 65535) ? 65535 : m_stall));
        end
    end

    initial begin
        #12 rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 64'(vld0), 64'd0);
        checkOutput("rst_out_data", 64'(dat0), 64'hDEAD_BEEF);
        checkOutput("rst_in_ready", 64'(rdy0), 64'd0);
        checkOutput("rst_occupancy", 64'(occ0), 64'd0);
        checkOutput("rst_stall", 64'(stl0), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_in_ready_before_edge", 64'(rdy0), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("rel_in_ready_first_edge", 64'(rdy0), 64'd1);
        checkOutput("rel_occupancy", 64'(occ0), 64'd0);
        chk_en = 1'b1;

        $display("[TB] streaming");
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput("stream_data", 64'(dat0), 64'(i));
            checkOutput("stream_valid", 64'(vld0), 64'd1);
            checkOutput("stream_ready", 64'(rdy0), 64'd1);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("stream_drained", 64'(vld0), 64'd0);
        checkOutput("stream_stall", 64'(stl0), 64'd0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_occupancy", 64'(occ0), 64'd2);
        checkOutput("bp_in_ready", 64'(rdy0), 64'd0);
        checkOutput("bp_data_held", 64'(dat0), 64'h11);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_data_held2", 64'(dat0), 64'h11);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_second", 64'(dat0), 64'h22);
        checkOutput("bp_ready_back", 64'(rdy0), 64'd1);
        checkOutput("bp_stall", 64'(stl0), 64'd2);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_empty", 64'(vld0), 64'd0);

        $display("[TB] lsb clear");
        applyStimulus(1'b1, 32'h0000_1003, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("lsb_clr_on", 64'(dat0), 64'h0000_1002);
        checkOutput("lsb_clr_disabled", 64'(dat1), 64'h0000_1003);
        applyStimulus(1'b1, 32'h0000_1003, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("lsb_clr_off", 64'(dat0), 64'h0000_1003);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] flush");
        applyStimulus(1'b1, 32'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hBB, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("fl_full", 64'(occ0), 64'd2);
        applyStimulus(1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("fl_valid", 64'(vld0), 64'd0);
        checkOutput("fl_occupancy", 64'(occ0), 64'd0);
        checkOutput("fl_in_ready", 64'(rdy0), 64'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("fl_still_empty", 64'(vld0), 64'd0);
        checkOutput("fl_data_kept", 64'(dat0), 64'hAA);

        $display("[TB] stall saturation");
        applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sat_stall4", 64'(stl0), 64'hF);
        checkOutput("sat_stall16", 64'(stl1), 64'd20);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("sat_clr", 64'(stl0), 64'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sat_recount", 64'(stl0), 64'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("sat_drained", 64'(vld0), 64'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            bit v;
            v = ($urandom_range(0, 9) < 6);
            applyStimulus(v, v ? 32'($urandom) : 32'hx, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) == 0),
                          ($urandom_range(0, 63) == 0));
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
